// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: accepts a binary value over valid/ready, shows it as hex
// or as BCD (sequential double-dabble) and scans it out digit by digit to a
// 7-segment decoder with active-low one-hot digit enables.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank most-significant zero digits).
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DIN_W       = 16,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              dec_mode,
    output logic [3:0]        bcd,
    output logic [DIGITS-1:0] digit_en,
    output logic              ovf
);

    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned CNT_W   = $clog2(DIN_W);
    localparam int unsigned LIMIT   = 10 ** DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;
    typedef enum logic [1:0] {M_HEX, M_DEC, M_ERR} mode_t;

    state_t             state_q;
    mode_t              mode_q;
    logic [DIN_W-1:0]   bin_q;
    logic [DIN_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIN_W-1:0]   disp_q;
    logic [DIGITS-1:0]  blank_q;

    logic [DIN_W-1:0]   bcd_adj_c;
    logic [DIN_W-1:0]   commit_val_c;
    logic [DIGITS-1:0]  blank_c;

    logic [PRESC_W-1:0] presc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [DIGITS-1:0]  sel_d;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj_c = acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                bcd_adj_c[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Value written to the display register at COMMIT
    always_comb begin
        commit_val_c = acc_q;
        case (mode_q)
            M_HEX:   commit_val_c = bin_q;
            M_ERR:   commit_val_c = {DIGITS{4'hE}};
            default: commit_val_c = acc_q;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank mask: a digit is blanked when it and every digit above it are zero; digit 0 never
    always_comb begin
        blank_c = '0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            if (k == int'(DIGITS) - 1) begin
                blank_c[k] = (commit_val_c[4*k +: 4] == 4'd0);
            end else begin
                blank_c[k] = blank_c[k+1] && (commit_val_c[4*k +: 4] == 4'd0);
            end
        end
    end
`else
    // Every digit is lit in its slot
    always_comb begin
        blank_c = '0;
    end
`endif

    // Accept / convert / commit state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= M_HEX;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            blank_q   <= '0;
            din_ready <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (din_valid && din_ready) begin
                        din_ready <= 1'b0;
                        bin_q     <= din;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        if (!dec_mode) begin
                            mode_q  <= M_HEX;
                            state_q <= S_COMMIT;
                        end else if (32'(din) < LIMIT) begin
                            mode_q  <= M_DEC;
                            state_q <= S_CONV;
                        end else begin
                            mode_q  <= M_ERR;
                            state_q <= S_COMMIT;
                        end
                    end
                end
                S_CONV: begin
                    acc_q <= {bcd_adj_c[DIN_W-2:0], bin_q[DIN_W-1]};
                    bin_q <= {bin_q[DIN_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIN_W - 1)) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    disp_q    <= commit_val_c;
                    blank_q   <= blank_c;
                    ovf       <= (mode_q == M_ERR);
                    din_ready <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Next digit index: advances on prescaler terminal count
    always_comb begin
        idx_d = idx_q;
        if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        sel_d = DIGITS'(1) << idx_d;
    end

    // Scanner: prescaler, digit index and registered decoder/anode outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            bcd      <= 4'd0;
            digit_en <= ~DIGITS'(1);
        end else begin
            presc_q  <= (presc_q == PRESC_W'(REFRESH_DIV - 1)) ? '0 : presc_q + PRESC_W'(1);
            idx_q    <= idx_d;
            bcd      <= disp_q[4*idx_d +: 4];
            digit_en <= ~sel_d | (blank_q & sel_d);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        dec_mode;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    seg7_scan_driver #(.DIGITS(4), .DIN_W(16), .REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dec_mode  (dec_mode),
        .bcd       (bcd),
        .digit_en  (digit_en),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a value and hold din_valid until it is accepted; returns at accept edge + 1
    task automatic send(input logic [15:0] v, input logic m);
        bit done;
        done      = 1'b0;
        din       = v;
        dec_mode  = m;
        din_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (din_ready) done = 1'b1;
            step();
        end
        din_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: value %h not accepted (ready=%b) required acceptance", v, din_ready);
        end
    endtask

    // Count samples with din_ready low, starting right after an accept edge
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (!din_ready && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    // Sync to the start of digit 0's slot and check one full scan frame plus the wrap
    task automatic check_scan(input string name, input logic [15:0] val, input logic [3:0] blank);
        logic [3:0] prev;
        logic [3:0] exp_en;
        logic [3:0] exp_nib;
        logic [3:0] mask;
        bit         synced;
        int         k;
        mask   = BLANK ? blank : 4'b0000;
        synced = 1'b0;
        step();
        for (int i = 0; i < 40 && !synced; i++) begin
            prev = digit_en;
            step();
            if (digit_en == 4'b1110 && prev != 4'b1110) synced = 1'b1;
        end
        n_checks++;
        if (!synced) begin
            n_fail++;
            $display("FAIL %s_sync: digit_en=%b never entered slot 0, required 1110", name, digit_en);
        end
        for (int i = 0; i < 16; i++) begin
            k       = i / 4;
            exp_nib = val[4*k +: 4];
            exp_en  = ~(4'b0001 << k) | (mask & (4'b0001 << k));
            n_checks++;
            if (digit_en !== exp_en || bcd !== exp_nib) begin
                n_fail++;
                $display("FAIL %s_cyc%0d: digit_en=%b bcd=%h required digit_en=%b bcd=%h",
                         name, i, digit_en, bcd, exp_en, exp_nib);
            end
            step();
        end
        n_checks++;
        if (digit_en !== 4'b1110 || bcd !== val[3:0]) begin
            n_fail++;
            $display("FAIL %s_wrap: digit_en=%b bcd=%h required digit_en=1110 bcd=%h",
                     name, digit_en, bcd, val[3:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; din_valid = 1'b0; dec_mode = 1'b0;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (din_ready !== 1'b1 || bcd !== 4'h0 || digit_en !== 4'b1110 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ready=%b bcd=%h en=%b ovf=%b required ready=1 bcd=0 en=1110 ovf=0",
                     din_ready, bcd, digit_en, ovf);
        end
    endtask

    task automatic test_hex();
        int c;
        send(16'hBEEF, 1'b0);
        count_busy(c);
        n_checks++;
        if (c != 1) begin
            n_fail++;
            $display("FAIL hex_latency: ready low %0d cycles required 1", c);
        end
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL hex_ovf: ovf=%b required 0", ovf);
        end
        check_scan("hex_beef", 16'hBEEF, 4'b0000);
    endtask

    task automatic test_decimal();
        int c;
        send(16'd1234, 1'b1);
        count_busy(c);
        n_checks++;
        if (c != 17) begin
            n_fail++;
            $display("FAIL dec_latency: ready low %0d cycles required 17", c);
        end
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_ovf: ovf=%b required 0", ovf);
        end
        check_scan("dec_1234", 16'h1234, 4'b0000);
    endtask

    task automatic test_overflow();
        int c;
        send(16'd10000, 1'b1);
        n_checks++;
        if (ovf !== 1'b0 || din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_accept: ovf=%b ready=%b required ovf=0 ready=0", ovf, din_ready);
        end
        step();
        n_checks++;
        if (ovf !== 1'b1 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b ready=%b required ovf=1 ready=1", ovf, din_ready);
        end
        check_scan("ovf_err", 16'hEEEE, 4'b0000);
        send(16'd7, 1'b1);
        count_busy(c);
        n_checks++;
        if (c != 17 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: busy=%0d ovf=%b required busy=17 ovf=0", c, ovf);
        end
        check_scan("dec_7", 16'h0007, 4'b1110);
    endtask

    task automatic test_back_to_back();
        int c;
        send(16'd1234, 1'b1);
        din       = 16'd99;
        dec_mode  = 1'b1;
        din_valid = 1'b1;
        count_busy(c);
        n_checks++;
        if (c != 17) begin
            n_fail++;
            $display("FAIL busy_hold: ready low %0d cycles with valid held, required 17", c);
        end
        step();
        din_valid = 1'b0;
        n_checks++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_accept: ready=%b after held valid required 0", din_ready);
        end
        count_busy(c);
        n_checks++;
        if (c != 17 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_conv: busy=%0d ovf=%b required busy=17 ovf=0", c, ovf);
        end
        check_scan("dec_99", 16'h0099, 4'b1100);
    endtask

    task automatic test_blank_42();
        send(16'd42, 1'b1);
        for (int i = 0; i < 20; i++) step();
        check_scan("dec_42", 16'h0042, 4'b1100);
    endtask

    task automatic test_reset_mid_conv();
        send(16'd42, 1'b1);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (din_ready !== 1'b1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: ready=%b ovf=%b required ready=1 ovf=0", din_ready, ovf);
        end
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (din_ready !== 1'b1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: ready=%b ovf=%b required ready=1 ovf=0", din_ready, ovf);
        end
        check_scan("midrst_zero", 16'h0000, 4'b1110);
    endtask

    initial begin
        test_reset();
        test_blank_42();
        test_hex();
        test_decimal();
        test_overflow();
        test_back_to_back();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
